// File: rtl/gcd_host_sequencer.sv
// gcd_host_sequencer: drives a bit-level GCD processor through its load protocol
// (reset pulse, then X and Y each presented on proc_data_in and strobed with an
// active-low proc_enter), waits for proc_halt and returns {x, y, gcd} to the host.
//
// Latency: the handshake edge N puts proc_reset low for cycle N+1. With default
// parameters proc_enter is low in cycles N+3 (X) and N+6 (Y), and WAIT_HALT starts
// in cycle N+8. res_valid rises on the edge after the first sampled proc_halt.
// Backpressure: one transaction in flight. in_ready is high only in IDLE. A result
// is held in RESULT until res_ready, and the pair offered during RESULT is not taken.
//
// Ports:
//   clock, reset                  single clock, asynchronous active-low reset
//   in_valid/in_ready, in_x/in_y  operand pair handshake
//   proc_reset, proc_enter        active-low controls to the processor
//   proc_data_in                  operand bus to the processor
//   proc_data_out, proc_halt      processor result and done flag
//   res_valid/res_ready           result handshake
//   res_x, res_y, res_gcd         echoed operands and captured GCD
//   res_timeout                   watchdog fired (only with GCD_HOST_TIMEOUT_EN)
//   busy                          high in every state except IDLE
//
// Optional feature: define GCD_HOST_TIMEOUT_EN to add a WAIT_HALT watchdog of
// TIMEOUT_CYCLES cycles. On expiry the block reports res_gcd=0 and res_timeout=1.
// Without the macro, WAIT_HALT waits forever and the res_timeout port is absent.
//
// Every output comes straight from a flop. Its next value is decoded from the
// next state, so outputs change on the same edge as the state they belong to.
module gcd_host_sequencer #(
  parameter int RST_CYCLES       = 1,
  parameter int SETUP_CYCLES     = 1,
  parameter int ENTER_LOW_CYCLES = 1,
  parameter int TIMEOUT_CYCLES   = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_x,
  input  logic [7:0] in_y,
  output logic       proc_reset,
  output logic       proc_enter,
  output logic [7:0] proc_data_in,
  input  logic [7:0] proc_data_out,
  input  logic       proc_halt,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_x,
  output logic [7:0] res_y,
  output logic [7:0] res_gcd,
`ifdef GCD_HOST_TIMEOUT_EN
  output logic       res_timeout,
`endif
  output logic       busy
);

  // One shared dwell counter serves all timed states, and the watchdog when it is
  // built. Its width is set by the longest dwell.
  localparam int MAX_RS = (RST_CYCLES > SETUP_CYCLES) ? RST_CYCLES : SETUP_CYCLES;
  localparam int MAX_RE = (MAX_RS > ENTER_LOW_CYCLES) ? MAX_RS : ENTER_LOW_CYCLES;
  localparam int MAX_C  = (MAX_RE > TIMEOUT_CYCLES) ? MAX_RE : TIMEOUT_CYCLES;
  localparam int CW     = (MAX_C < 2) ? 1 : $clog2(MAX_C + 1);

  localparam logic [CW-1:0] RST_LAST   = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] ENTER_LAST = CW'(ENTER_LOW_CYCLES - 1);
`ifdef GCD_HOST_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [3:0] {
    S_IDLE,
    S_PRST,
    S_XSETUP,
    S_XPULSE,
    S_XHOLD,
    S_YSETUP,
    S_YPULSE,
    S_YHOLD,
    S_WAIT_HALT,
    S_RESULT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    x_q, y_q;
  logic          accept, capture, timeout_hit;

  logic          in_ready_q, in_ready_d;
  logic          proc_reset_q, proc_reset_d;
  logic          proc_enter_q, proc_enter_d;
  logic [7:0]    proc_data_q, proc_data_d;
  logic          res_valid_q, res_valid_d;
  logic [7:0]    res_x_q, res_y_q, res_gcd_q;
  logic          busy_q, busy_d;
`ifdef GCD_HOST_TIMEOUT_EN
  logic          res_timeout_q;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    accept      = 1'b0;
    capture     = 1'b0;
    timeout_hit = 1'b0;

    case (state_q)
      S_IDLE: begin
        // in_ready_q stays low for the first cycle after reset, so an offer in
        // that cycle waits one more cycle.
        if (in_valid && in_ready_q) begin
          accept  = 1'b1;
          state_d = S_PRST;
        end
      end
      S_PRST:   if (cnt_q == RST_LAST)   state_d = S_XSETUP;
      S_XSETUP: if (cnt_q == SETUP_LAST) state_d = S_XPULSE;
      S_XPULSE: if (cnt_q == ENTER_LAST) state_d = S_XHOLD;
      S_XHOLD:                           state_d = S_YSETUP;
      S_YSETUP: if (cnt_q == SETUP_LAST) state_d = S_YPULSE;
      S_YPULSE: if (cnt_q == ENTER_LAST) state_d = S_YHOLD;
      S_YHOLD:                           state_d = S_WAIT_HALT;
      S_WAIT_HALT: begin
        // proc_halt is looked at only here. A halt raised earlier, for example a
        // stale one from the previous run, has no effect.
        if (proc_halt) begin
          capture = 1'b1;
          state_d = S_RESULT;
        end
`ifdef GCD_HOST_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          timeout_hit = 1'b1;
          state_d     = S_RESULT;
        end
`endif
      end
      S_RESULT: if (res_valid_q && res_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Each state's dwell count starts from zero on entry.
    if (state_d != state_q) cnt_d = '0;
  end

  // ---------------------------------------------------------------------------
  // Registered outputs, decoded from the next state
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready_d   = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
    res_valid_d  = (state_d == S_RESULT);
    proc_reset_d = (state_d != S_PRST);
    proc_enter_d = !((state_d == S_XPULSE) || (state_d == S_YPULSE));

    // X is on the bus from XSETUP through XHOLD. Y is on the bus from YSETUP and
    // stays there until the next X phase, so the processor input never glitches
    // between transactions.
    proc_data_d = proc_data_q;
    case (state_d)
      S_XSETUP, S_XPULSE, S_XHOLD: proc_data_d = x_q;
      S_YSETUP, S_YPULSE, S_YHOLD: proc_data_d = y_q;
      default:                     proc_data_d = proc_data_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      in_ready_q   <= 1'b0;
      proc_reset_q <= 1'b0;
      proc_enter_q <= 1'b1;
      proc_data_q  <= '0;
      res_valid_q  <= 1'b0;
      res_x_q      <= '0;
      res_y_q      <= '0;
      res_gcd_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      in_ready_q   <= in_ready_d;
      proc_reset_q <= proc_reset_d;
      proc_enter_q <= proc_enter_d;
      proc_data_q  <= proc_data_d;
      res_valid_q  <= res_valid_d;
      busy_q       <= busy_d;
      if (accept) begin
        x_q <= in_x;
        y_q <= in_y;
      end
      if (capture || timeout_hit) begin
        res_x_q   <= x_q;
        res_y_q   <= y_q;
        res_gcd_q <= capture ? proc_data_out : 8'h00;
      end
    end
  end

`ifdef GCD_HOST_TIMEOUT_EN
  // The flag stays visible after the result is consumed and clears on the next accept.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      res_timeout_q <= 1'b0;
    end else if (accept) begin
      res_timeout_q <= 1'b0;
    end else if (timeout_hit) begin
      res_timeout_q <= 1'b1;
    end
  end

  assign res_timeout = res_timeout_q;
`endif

  assign in_ready     = in_ready_q;
  assign proc_reset   = proc_reset_q;
  assign proc_enter   = proc_enter_q;
  assign proc_data_in = proc_data_q;
  assign res_valid    = res_valid_q;
  assign res_x        = res_x_q;
  assign res_y        = res_y_q;
  assign res_gcd      = res_gcd_q;
  assign busy         = busy_q;

endmodule
